// File: rtl/fetch_defs.sv
// Shared definitions for the fetch stage: state encodings, widths and PC step.
package fetch_defs;

   localparam int INSTR_W = 16;
   localparam logic [15:0] PC_STEP = 16'd2;
   localparam logic [INSTR_W-1:0] DEF_NOP_INSTR = 16'h0800;

   typedef enum logic [2:0] {
      ST_REQ    = 3'd0,
      ST_WAIT   = 3'd1,
      ST_HOLD   = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_HALTED = 3'd4
   } fetch_state_e;

   // Wraps mod 2^16 by construction of the 16-bit sum.
   function automatic logic [15:0] pc_next(input logic [15:0] pc);
      return pc + PC_STEP;
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// One-entry instruction buffer presented to decode; load has priority over clear.
module fetch_buffer
   import fetch_defs::*;
#(
   parameter logic [INSTR_W-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               load,
   input  logic               clear,
   input  logic [INSTR_W-1:0] instr_in,
   input  logic [15:0]        pc_in,
   output logic               id_valid,
   output logic [INSTR_W-1:0] id_instr,
   output logic [15:0]        id_pc,
   output logic [15:0]        id_pc_inc
);

   logic               valid_d, valid_q;
   logic [INSTR_W-1:0] instr_d, instr_q;
   logic [15:0]        pc_d, pc_q;
   logic [15:0]        pc_inc_d, pc_inc_q;

   always_comb begin
      valid_d  = valid_q;
      instr_d  = instr_q;
      pc_d     = pc_q;
      pc_inc_d = pc_inc_q;
      if (load) begin
         valid_d  = 1'b1;
         instr_d  = instr_in;
         pc_d     = pc_in;
         pc_inc_d = pc_next(pc_in);
      end else if (clear) begin
         valid_d = 1'b0;
         instr_d = NOP_INSTR;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q  <= 1'b0;
         instr_q  <= NOP_INSTR;
         pc_q     <= 16'h0000;
         pc_inc_q <= 16'h0000;
      end else begin
         valid_q  <= valid_d;
         instr_q  <= instr_d;
         pc_q     <= pc_d;
         pc_inc_q <= pc_inc_d;
      end
   end

   assign id_valid  = valid_q;
   assign id_instr  = instr_q;
   assign id_pc     = pc_q;
   assign id_pc_inc = pc_inc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, multi-cycle imem handshake, one-entry decode buffer.
// Optional perf counters enabled with `define FETCH_PERF_EN.
module fetch_stage
   import fetch_defs::*;
#(
   parameter logic [15:0]        RESET_PC  = 16'h0000,
   parameter logic [INSTR_W-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
   input  logic               clk,
   input  logic               rst,
   output logic [15:0]        imem_addr,
   output logic               imem_en,
   input  logic               imem_stall,
   input  logic               imem_done,
   input  logic [INSTR_W-1:0] imem_data,
   input  logic               imem_err,
   input  logic               redirect_valid,
   input  logic [15:0]        redirect_pc,
   input  logic               halt,
   input  logic               id_ready,
   output logic               id_valid,
   output logic [INSTR_W-1:0] id_instr,
   output logic [15:0]        id_pc,
   output logic [15:0]        id_pc_inc,
   output logic               err
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0]        perf_fetched,
   output logic [15:0]        perf_stall
`endif
);

   fetch_state_e state_d, state_q;
   logic [15:0]  pc_d, pc_q;
   logic         pc_we;
   logic         halted_d, halted_q;
   logic         err_d, err_q;
   logic         buf_load, buf_clear;
   logic         stop, redir;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      pc_we     = 1'b0;
      halted_d  = halted_q | halt;
      err_d     = err_q;
      buf_load  = 1'b0;
      buf_clear = 1'b0;
      stop      = halt | halted_q;
      // Halt beats redirect, and nothing redirects once halted.
      redir     = redirect_valid & ~stop & (state_q != ST_HALTED);

      if (redir) begin
         pc_we     = 1'b1;
         pc_d      = {redirect_pc[15:1], 1'b0};
         buf_clear = 1'b1;
         if (redirect_pc[0]) err_d = 1'b1;
      end
      if (state_q == ST_WAIT && imem_done && imem_err) err_d = 1'b1;

      case (state_q)
         ST_REQ: begin
            if (stop)             state_d = ST_HALTED;
            else if (redir)       state_d = ST_REQ;
            else if (!imem_stall) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (imem_done) begin
               if (stop)       state_d = ST_HALTED;
               else if (redir) state_d = ST_REQ;
               else begin
                  buf_load = 1'b1;
                  pc_we    = 1'b1;
                  pc_d     = pc_next(pc_q);
                  state_d  = ST_HOLD;
               end
            end else if (!stop && redir) begin
               state_d = ST_DRAIN;
            end
         end
         ST_HOLD: begin
            if (stop) begin
               state_d = ST_HALTED;
               if (id_ready) buf_clear = 1'b1;
            end else if (redir) begin
               state_d = ST_REQ;
            end else if (id_ready) begin
               buf_clear = 1'b1;
               state_d   = ST_REQ;
            end
         end
         ST_DRAIN: begin
            if (imem_done) state_d = stop ? ST_HALTED : ST_REQ;
         end
         ST_HALTED: begin
            // Decode may still drain the instruction buffered before halt.
            if (id_ready) buf_clear = 1'b1;
         end
         default: state_d = ST_REQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_REQ;
         pc_q     <= RESET_PC;
         halted_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         halted_q <= halted_d;
         err_q    <= err_d;
         if (pc_we) pc_q <= pc_d;
      end
   end

   fetch_buffer #(.NOP_INSTR(NOP_INSTR)) u_buf (
      .clk       (clk),
      .rst       (rst),
      .load      (buf_load),
      .clear     (buf_clear),
      .instr_in  (imem_data),
      .pc_in     (pc_q),
      .id_valid  (id_valid),
      .id_instr  (id_instr),
      .id_pc     (id_pc),
      .id_pc_inc (id_pc_inc)
   );

   assign imem_addr = pc_q;
   assign imem_en   = (state_q == ST_REQ);
   assign err       = err_q;

`ifdef FETCH_PERF_EN
   logic [15:0] perf_fetched_d, perf_fetched_q;
   logic [15:0] perf_stall_d, perf_stall_q;
   logic        stall_cyc;

   always_comb begin
      stall_cyc      = (state_q == ST_REQ && imem_stall) ||
                       (state_q == ST_WAIT) || (state_q == ST_DRAIN);
      perf_fetched_d = perf_fetched_q;
      perf_stall_d   = perf_stall_q;
      if (buf_load && perf_fetched_q != 16'hFFFF) perf_fetched_d = perf_fetched_q + 16'd1;
      if (stall_cyc && perf_stall_q != 16'hFFFF)  perf_stall_d   = perf_stall_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetched_q <= 16'h0000;
         perf_stall_q   <= 16'h0000;
      end else begin
         perf_fetched_q <= perf_fetched_d;
         perf_stall_q   <= perf_stall_d;
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage for the 16-bit processor. It sits directly upstream of decode and replaces the fixed pc+2 fetch path. It owns the PC, issues reads to a multi-cycle instruction memory (stall/done handshake), and buffers one fetched instruction for decode under a valid/ready handshake. It accepts branch/jump redirects and a sticky halt from downstream.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
NOP_INSTR, 16'h0800, value driven on id_instr when the buffer is invalid

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
imem_addr  out  16  read address; equals current pc
imem_en  out  1  read request; high only in state REQ
imem_stall  in  1  memory busy; request not accepted this cycle
imem_done  in  1  read data valid this cycle
imem_data  in  16  instruction returned with imem_done
imem_err  in  1  memory error, sampled with imem_done
redirect_valid  in  1  branch/jump taken; load redirect_pc
redirect_pc  in  16  target PC
halt  in  1  HALT decoded; stop fetching (sticky until rst)
id_ready  in  1  decode consumes buffer this cycle
id_valid  out  1  buffer holds a valid instruction
id_instr  out  16  buffered instruction
id_pc  out  16  PC of buffered instruction
id_pc_inc  out  16  id_pc + 2, for link and branch-base use
err  out  1  sticky error flag

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values: pc=RESET_PC, state=REQ, id_valid=0, id_instr=NOP_INSTR, id_pc=0, id_pc_inc=0, err=0, halted=0. The first request is issued in the first cycle after rst falls. rst has priority over everything, including mid-request. Any in-flight memory response after reset is not expected; the memory is reset by the same rst.
- FSM states: REQ, WAIT, HOLD, DRAIN, HALTED.
- REQ:
  - imem_en=1.
  - If imem_stall=1, remain in REQ.
  - Otherwise the request is accepted and the next state is WAIT.
- WAIT:
  - On imem_done, capture imem_data into id_instr, set id_pc=pc, id_pc_inc=pc+2, id_valid=1, pc<=pc+2, and go to HOLD.
  - Minimum fetch latency is 2 cycles from the accepting REQ cycle to id_valid=1.
- HOLD:
  - If id_ready=1, clear id_valid, set id_instr=NOP_INSTR, and go to REQ.
  - Otherwise hold all buffer outputs stable.
- Redirect (redirect_valid=1) is evaluated before normal transitions. It always sets pc<=redirect_pc and clears id_valid.
  - From REQ or HOLD: go to REQ.
  - From WAIT without imem_done: go to DRAIN.
  - From WAIT with imem_done in the same cycle: discard the data and go to REQ.
- DRAIN:
  - On imem_done, discard the data and go to REQ.
  - A further redirect updates pc and stays in DRAIN.
- Halt:
  - halt=1 sets halted.
  - From REQ or HOLD: go to HALTED immediately. id_valid is kept if already set (decode finishes the buffered instruction).
  - From WAIT or DRAIN: wait for imem_done, discard the data, then go to HALTED.
  - In HALTED, imem_en=0 and redirect is ignored; the only exit is rst.
  - halt and redirect in the same cycle: halt wins.
- PC arithmetic: pc+2 is computed mod 2^16 (0xFFFE -> 0x0000, no flag).
- Errors:
  - err is set if imem_done and imem_err are both high in WAIT (buffer still loaded).
  - err is set if redirect_valid is accepted with redirect_pc[0]=1; pc is loaded with bit 0 cleared.
  - err is sticky until rst.

Optional Feature:
FETCH_PERF_EN: when defined, adds outputs perf_fetched (16, count of instructions loaded into the buffer) and perf_stall (16, count of cycles in REQ with imem_stall=1 plus cycles in WAIT or DRAIN). Both counters reset to 0 on rst and saturate at 16'hFFFF. When undefined, these ports and the counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared defines file fetch_defs: state encodings (3-bit), INSTR_W=16, PC_STEP=2, NOP_INSTR.
- Sub-module fetch_buffer: holds id_valid, id_instr, id_pc and id_pc_inc, with load, clear and hold controls.
- The PC uses the existing register block with an explicit write enable.

Test Plan:
- Reset then no stalls, done 1 cycle after accept, id_ready=1 -> instructions at pc 0x0000, 0x0002, 0x0004 are each presented with id_valid=1 and the correct id_pc_inc.
- imem_stall=1 for 3 cycles in REQ -> imem_en held high with imem_addr stable; perf_stall=3 (FETCH_PERF_EN).
- id_ready=0 for 4 cycles in HOLD -> id_instr/id_pc stable, no new imem_en; then id_ready=1 -> next request at pc+2.
- redirect_valid=1 (redirect_pc=0x0040) during WAIT, done 2 cycles later -> returned data discarded, id_valid stays 0, next imem_addr=0x0040.
- halt=1 during WAIT -> after imem_done, imem_en stays 0 indefinitely; a later redirect to 0x0100 has no effect.
- redirect_pc=0x0013 -> err=1 and persists; next imem_addr=0x0012; pc at 0xFFFE fetches then wraps to 0x0000.
